// File: rtl/data_mem_mmio.sv
// Data-side responder for the single-cycle RV64 core.
// It holds a doubleword RAM plus an MMIO block with a UART TX FIFO, a UART status word and a cycle counter.
module data_mem_mmio #(
    parameter int unsigned RAM_DEPTH    = 1024,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [63:0] MMIO_BASE    = 64'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  dm_rd_ctrl,
    input  logic [2:0]  dm_wr_ctrl,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_din,
    output logic [63:0] dm_dout,
    output logic        uart_tx
);
    localparam int unsigned   AW        = $clog2(RAM_DEPTH);
    localparam int unsigned   BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLE  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic [63:0]   mem [RAM_DEPTH];
    logic [7:0]    fifo [4];

    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [1:0]    reg_sel;

    logic [7:0]    wr_mask;
    logic [63:0]   wr_data;
    logic [63:0]   wr_bits;

    logic [63:0]   cycle;
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    count;
    uart_state_t   state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] baud;

    logic          fifo_full;
    logic          tx_busy;
    logic          push_ok;
    logic          pop;
    logic          cycle_wr;

    logic [63:0]   status;
    logic [63:0]   rd_dw;
    logic [7:0]    b_lane;
    logic [15:0]   h_lane;
    logic [31:0]   w_lane;

    assign ram_hit  = (dm_addr >> (AW + 3)) == 64'd0;
    assign mmio_hit = dm_addr[63:5] == MMIO_BASE[63:5];
    assign ram_idx  = dm_addr[AW+2:3];
    assign reg_sel  = dm_addr[4:3];

    // Store lane enables and right-aligned data replicated across every lane
    always_comb begin
        wr_mask = 8'h00;
        wr_data = 64'd0;
        wr_bits = 64'd0;
        case (dm_wr_ctrl)
            3'b001: begin
                wr_mask = 8'h01 << dm_addr[2:0];
                wr_data = {8{dm_din[7:0]}};
            end
            3'b010: begin
                wr_mask = 8'h03 << {dm_addr[2:1], 1'b0};
                wr_data = {4{dm_din[15:0]}};
            end
            3'b011: begin
                wr_mask = 8'h0F << {dm_addr[2], 2'b00};
                wr_data = {2{dm_din[31:0]}};
            end
            3'b100: begin
                wr_mask = 8'hFF;
                wr_data = dm_din;
            end
            default: ;
        endcase
        for (int i = 0; i < 8; i++) begin
            wr_bits[8*i +: 8] = {8{wr_mask[i]}};
        end
    end

    assign fifo_full = count == 3'd4;
    assign tx_busy   = (state != S_IDLE) || (count != 3'd0);
    assign push_ok   = !rst && mmio_hit && (reg_sel == REG_TXDATA) && (wr_mask != 8'h00) && !fifo_full;
    assign pop       = (state == S_IDLE) && (count != 3'd0);
    assign cycle_wr  = mmio_hit && (reg_sel == REG_CYCLE) && (wr_mask != 8'h00);
    assign status    = {59'd0, count, tx_busy, fifo_full};

    always_ff @(posedge clk) begin
        if (!rst && ram_hit) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_mask[i]) begin
                    mem[ram_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo[wr_ptr] <= dm_din[7:0];
        end
    end

    // Cycle counter, FIFO bookkeeping and the UART transmitter FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle   <= 64'd0;
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
            state   <= S_IDLE;
            shift   <= 8'd0;
            bit_cnt <= 3'd0;
            baud    <= '0;
            uart_tx <= 1'b1;
        end else begin
            cycle <= cycle_wr ? ((cycle & ~wr_bits) | (wr_data & wr_bits)) : cycle + 64'd1;

            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase

            case (state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift   <= fifo[rd_ptr];
                        bit_cnt <= 3'd0;
                        baud    <= '0;
                        state   <= S_START;
                        uart_tx <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        state   <= S_DATA;
                        uart_tx <= shift[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state   <= S_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        state   <= S_IDLE;
                        uart_tx <= 1'b1;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    // Combinational load path: pick the doubleword, then the lane, then extend
    always_comb begin
        rd_dw = 64'd0;
        if (ram_hit) begin
            rd_dw = mem[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                REG_STATUS: rd_dw = status;
                REG_CYCLE:  rd_dw = cycle;
                default:    rd_dw = 64'd0;
            endcase
        end
        b_lane = rd_dw[{dm_addr[2:0], 3'b000} +: 8];
        h_lane = rd_dw[{dm_addr[2:1], 4'b0000} +: 16];
        w_lane = rd_dw[{dm_addr[2], 5'b00000} +: 32];
        case (dm_rd_ctrl)
            3'b001:  dm_dout = {{56{b_lane[7]}}, b_lane};
            3'b010:  dm_dout = {56'd0, b_lane};
            3'b011:  dm_dout = {{48{h_lane[15]}}, h_lane};
            3'b100:  dm_dout = {48'd0, h_lane};
            3'b101:  dm_dout = {{32{w_lane[31]}}, w_lane};
            3'b110:  dm_dout = {32'd0, w_lane};
            3'b111:  dm_dout = rd_dw;
            default: dm_dout = 64'd0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM lanes/extension, MMIO registers, UART framing, FIFO overflow and reset.
module tb_data_mem_mmio;
    localparam int unsigned CPB = 4;
    localparam logic [63:0] TXD = 64'h1000_0000;
    localparam logic [63:0] STA = 64'h1000_0008;
    localparam logic [63:0] CYC = 64'h1000_0010;
    localparam logic [63:0] RSV = 64'h1000_0018;

    localparam logic [2:0] R_NONE = 3'd0, R_LB = 3'd1, R_LBU = 3'd2, R_LH = 3'd3, R_LHU = 3'd4;
    localparam logic [2:0] R_LW = 3'd5, R_LWU = 3'd6, R_LD = 3'd7;
    localparam logic [2:0] W_NONE = 3'd0, W_SB = 3'd1, W_SH = 3'd2, W_SW = 3'd3, W_SD = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  dm_rd_ctrl = R_NONE;
    logic [2:0]  dm_wr_ctrl = W_NONE;
    logic [63:0] dm_addr = 64'd0;
    logic [63:0] dm_din = 64'd0;
    logic [63:0] dm_dout;
    logic        uart_tx;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  rx_b;
    logic [9:0]  frame;
    int          n;

    data_mem_mmio #(
        .RAM_DEPTH   (1024),
        .CLKS_PER_BIT(CPB),
        .MMIO_BASE   (64'h1000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dm_rd_ctrl(dm_rd_ctrl),
        .dm_wr_ctrl(dm_wr_ctrl),
        .dm_addr   (dm_addr),
        .dm_din    (dm_din),
        .dm_dout   (dm_dout),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    // Serial receiver: finds a start bit, samples mid-bit, keeps bytes with a valid stop bit
    always begin
        @(negedge clk);
        if (rst === 1'b0 && uart_tx === 1'b0) begin
            repeat (CPB + CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                rx_b[i] = uart_tx;
                if (i < 7) repeat (CPB) @(negedge clk);
            end
            repeat (CPB) @(negedge clk);
            if (uart_tx === 1'b1) rx_q.push_back(rx_b);
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [2:0] w, input logic [63:0] a, input logic [63:0] d);
        dm_rd_ctrl = R_NONE;
        dm_wr_ctrl = w;
        dm_addr    = a;
        dm_din     = d;
        tick();
        dm_wr_ctrl = W_NONE;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] r, input logic [63:0] a, input logic [63:0] exp);
        dm_rd_ctrl = r;
        dm_addr    = a;
        #1;
        check(tag, dm_dout, exp);
        dm_rd_ctrl = R_NONE;
    endtask

    initial begin
        // Reset state and counter start
        repeat (3) tick();
        check("rst_uart_tx", 64'(uart_tx), 64'd1);
        load_chk("rst_status", R_LD, STA, 64'd0);
        rst = 1'b0;
        load_chk("cycle_0", R_LD, CYC, 64'd0);
        repeat (10) tick();
        load_chk("cycle_10", R_LD, CYC, 64'd10);

        // Counter store and wrap
        store(W_SD, CYC, 64'hFFFF_FFFF_FFFF_FFFE);
        load_chk("cycle_fe", R_LD, CYC, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        load_chk("cycle_ff", R_LD, CYC, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        load_chk("cycle_wrap", R_LD, CYC, 64'd0);
        store(W_SW, CYC + 64'd4, 64'h1234_5678);
        load_chk("cycle_merge", R_LD, CYC, 64'h1234_5678_0000_0000);
        load_chk("cycle_lw_hi", R_LW, CYC + 64'd4, 64'h0000_0000_1234_5678);

        // Read-only / reserved MMIO slots
        store(W_SD, STA, 64'hFFFF_FFFF_FFFF_FFFF);
        store(W_SD, RSV, 64'hFFFF_FFFF_FFFF_FFFF);
        load_chk("status_ro", R_LD, STA, 64'd0);
        load_chk("rsv_zero", R_LD, RSV, 64'd0);
        load_chk("txdata_rd0", R_LD, TXD, 64'd0);
        check("status_ro_tx", 64'(uart_tx), 64'd1);

        // Store/load lanes and extension
        store(W_SD, 64'h40, 64'h8877_6655_4433_2211);
        load_chk("lb_47", R_LB, 64'h47, 64'hFFFF_FFFF_FFFF_FF88);
        load_chk("lbu_47", R_LBU, 64'h47, 64'h88);
        load_chk("lh_42", R_LH, 64'h42, 64'h4433);
        load_chk("lh_46", R_LH, 64'h46, 64'hFFFF_FFFF_FFFF_8877);
        load_chk("lhu_46", R_LHU, 64'h46, 64'h8877);
        load_chk("lwu_44", R_LWU, 64'h44, 64'h8877_6655);
        load_chk("lw_44", R_LW, 64'h44, 64'hFFFF_FFFF_8877_6655);
        load_chk("ld_40", R_LD, 64'h40, 64'h8877_6655_4433_2211);
        load_chk("none_0", R_NONE, 64'h40, 64'd0);

        // Partial stores and misaligned access masking
        store(W_SD, 64'h48, 64'd0);
        store(W_SB, 64'h49, 64'hAB);
        store(W_SH, 64'h4C, 64'h1234);
        load_chk("ld_48", R_LD, 64'h48, 64'h0000_1234_0000_AB00);
        load_chk("lh_4d", R_LH, 64'h4D, 64'h1234);
        store(W_SW, 64'h4B, 64'h89AB_CDEF);
        load_chk("lwu_49", R_LWU, 64'h49, 64'h89AB_CDEF);
        load_chk("ld_48_sw", R_LD, 64'h48, 64'h0000_1234_89AB_CDEF);

        // Load and store to the same address in one cycle
        dm_wr_ctrl = W_SD;
        dm_din     = 64'h5555;
        dm_addr    = 64'h48;
        dm_rd_ctrl = R_LD;
        #1;
        check("rw_same_old", dm_dout, 64'h0000_1234_89AB_CDEF);
        tick();
        dm_wr_ctrl = W_NONE;
        check("rw_same_new", dm_dout, 64'h5555);
        dm_rd_ctrl = R_NONE;

        // Decode boundaries: top of RAM, just past it, and high address bits
        store(W_SD, 64'h0, 64'h1111_2222_3333_4444);
        store(W_SD, 64'h2000, 64'hDEAD);
        store(W_SD, 64'h1FF8, 64'hCAFE_F00D_1234_5678);
        store(W_SB, 64'h8000_0000_0000_0040, 64'h00);
        load_chk("ram_0", R_LD, 64'h0, 64'h1111_2222_3333_4444);
        load_chk("unmapped_2000", R_LD, 64'h2000, 64'd0);
        load_chk("ram_top", R_LD, 64'h1FF8, 64'hCAFE_F00D_1234_5678);
        load_chk("no_alias_40", R_LD, 64'h40, 64'h8877_6655_4433_2211);

        // Single UART frame of 0xA5
        frame = {1'b1, 8'hA5, 1'b0};
        store(W_SB, TXD, 64'hA5);
        load_chk("frame_queued", R_LD, STA, 64'h6);
        check("frame_idle_tx", 64'(uart_tx), 64'd1);
        tick();
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                check($sformatf("frame_bit%0d_c%0d", k, c), 64'(uart_tx), 64'(frame[k]));
                if (k == 5 && c == 0) load_chk("frame_busy", R_LD, STA, 64'h2);
                tick();
            end
        end
        load_chk("frame_done", R_LD, STA, 64'd0);
        n = int'(rx_q.size());
        check("frame_rx_count", 64'(n), 64'd1);
        if (n > 0) check("frame_rx_byte", 64'(rx_q[0]), 64'hA5);
        rx_q.delete();

        // FIFO overflow: six back-to-back pushes, sixth dropped
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) load_chk("ovf_full", R_LD, STA, 64'h13);
            store(W_SB, TXD, 64'(i));
        end
        load_chk("ovf_drop", R_LD, STA, 64'h13);
        for (int i = 0; i < 600; i++) begin
            if (rx_q.size() >= 5) break;
            tick();
        end
        repeat (40) tick();
        n = int'(rx_q.size());
        check("ovf_rx_count", 64'(n), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("ovf_byte%0d", i), (i < n) ? 64'(rx_q[i]) : {64{1'bx}}, 64'(i + 1));
        end
        load_chk("ovf_idle", R_LD, STA, 64'd0);
        check("ovf_idle_tx", 64'(uart_tx), 64'd1);

        // Reset mid-frame with two bytes queued
        store(W_SB, TXD, 64'h11);
        store(W_SB, TXD, 64'h22);
        store(W_SB, TXD, 64'h33);
        repeat (4) tick();
        load_chk("pre_rst_status", R_LD, STA, 64'h0A);
        rst        = 1'b1;
        dm_wr_ctrl = W_SD;
        dm_addr    = 64'h48;
        dm_din     = 64'hBAD0_BAD0;
        tick();
        dm_wr_ctrl = W_NONE;
        check("rst_mid_tx", 64'(uart_tx), 64'd1);
        load_chk("rst_mid_status", R_LD, STA, 64'd0);
        load_chk("rst_mid_cycle", R_LD, CYC, 64'd0);
        rst = 1'b0;
        load_chk("rst_ram_40", R_LD, 64'h40, 64'h8877_6655_4433_2211);
        load_chk("rst_ram_48", R_LD, 64'h48, 64'h5555);
        load_chk("unmapped_2000_0000", R_LD, 64'h2000_0000, 64'd0);
        repeat (60) tick();
        check("rst_no_resend_tx", 64'(uart_tx), 64'd1);
        load_chk("rst_no_resend_status", R_LD, STA, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side responder for the single-cycle RV64 core: it is the other end of the core's `dm_*` port. It decodes `dm_addr` into a doubleword-organised RAM and three memory-mapped registers:

- a UART transmitter with a 4-entry FIFO;
- a UART status word;
- a free-running 64-bit cycle counter.

Loads return combinationally in the same cycle, as the single-cycle datapath requires. Stores commit on the clock edge.

## Interface
- `RAM_DEPTH`, 1024: RAM size in 64-bit doublewords; power of two.
- `CLKS_PER_BIT`, 16: `clk` cycles per UART bit; ≥2.
- `MMIO_BASE`, 64'h1000_0000: base address of the register block.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `dm_rd_ctrl` in 3: load type. 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110 LWU, 111 LD.
- `dm_wr_ctrl` in 3: store type. 000 none, 001 SB, 010 SH, 011 SW, 100 SD, others none.
- `dm_addr` in 64: byte address.
- `dm_din` in 64: store data, right-aligned.
- `dm_dout` out 64: load data, sign- or zero-extended per `dm_rd_ctrl`.
- `uart_tx` out 1: serial 8N1 output; idles high.

## Operation
- **Decode**
  - RAM hit: `dm_addr < RAM_DEPTH*8`.
  - MMIO hit: `dm_addr[63:5] == MMIO_BASE[63:5]`.
  - Everything else is unmapped: loads return 0, stores are ignored.
- **Alignment**
  - Doubleword index is `dm_addr[63:3]`.
  - Low address bits are masked to natural alignment: LH/SH ignore bit 0; LW/SW ignore bits 1:0; LD/SD ignore bits 2:0.
  - Accesses never cross a doubleword.
- **Lanes**
  - Byte lane = `dm_addr[2:0]`, halfword lane = `dm_addr[2:1]`, word lane = `dm_addr[2]`.
  - Stores write only the selected bytes; the other bytes of the doubleword are untouched.
- **Extension**
  - LB, LH and LW sign-extend from bit 7, 15 and 31 respectively.
  - LBU, LHU and LWU zero-extend.
  - LD returns all 64 bits.
  - `dm_rd_ctrl` = 000 drives `dm_dout` = 0.
- **MMIO registers** (offset from `MMIO_BASE`)
  - +0x00 TXDATA
    - A store of any width pushes `dm_din[7:0]` into the FIFO.
    - The push is dropped silently if the FIFO count is 4 at that edge.
    - Reads return 0.
  - +0x08 STATUS (read-only)
    - bit0 = FIFO full.
    - bit1 = transmitter busy (state ≠ IDLE or count ≠ 0).
    - bits 4:2 = FIFO count (0..4).
    - Other bits read 0; stores are ignored.
  - +0x10 CYCLE
    - Increments by 1 every cycle, wrapping at 2^64.
    - A store merges `dm_din` into the selected bytes; the merged value appears next cycle and the counter does not also increment on that edge.
    - Loads use the normal lane and extension rules.
  - +0x18 reads 0 and ignores stores.
- **UART FIFO**
  - 4 entries, with 2-bit read/write pointers that wrap and a 3-bit count.
  - A push and a pop on the same edge leave the count unchanged.
  - The full check uses the count before the edge. A push at count 4 is dropped even if a pop happens on the same edge.
- **UART FSM**: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `uart_tx`=1. If count>0, pop the head into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `uart_tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: drive shift[0], LSB first, for 8 bits of `CLKS_PER_BIT` cycles each; shift right after each bit.
  - STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles, then return to IDLE.
  - Frame length is 10×`CLKS_PER_BIT` cycles, plus 1 IDLE cycle before the next pop.
- **Reset**
  - Clears CYCLE, FIFO pointers and count, shift register, bit counter and baud counter.
  - FSM goes to IDLE and `uart_tx`=1.
  - RAM contents are not reset.
  - Reset mid-frame aborts the frame, discards queued bytes, and takes `uart_tx` high on the next edge.
  - Stores during a reset cycle are ignored.

## Timing
- Loads are combinational, with zero latency from `dm_addr`/`dm_rd_ctrl` to `dm_dout`.
- Stores take effect at the rising edge and are visible to loads in the following cycle.
- If a load and a store to the same address occur in one cycle, the load returns the old data.
- STATUS reflects register state before the current edge.
- `uart_tx` is a register output.
- START begins one cycle after the push edge when the FIFO was empty and the FSM was IDLE.
- CYCLE reads N in the cycle that is N cycles after reset deassertion (first read after reset = 0).

## Test plan
- **Store/load lanes:** SD 0x8877665544332211 @0x40; then LB @0x47 → 0xFFFFFFFFFFFFFF88 (sign-extended 0x88), LBU @0x47 → 0x88, LH @0x42 → 0x4433, LWU @0x44 → 0x88776655, LW @0x44 → 0xFFFFFFFF88776655.
- **Partial store:** SD 0 @0x48, then SB 0xAB @0x49 and SH 0x1234 @0x4C; LD @0x48 → 0x000012340000AB00. Misaligned LH @0x4D returns the lane at 0x4C, i.e. 0x1234.
- **UART frame:** `CLKS_PER_BIT`=4, SB 0xA5 to TXDATA.
  - `uart_tx` reads 0, 1,0,1,0,0,1,0,1, 1, with each bit held 4 cycles.
  - STATUS bit1=1 during the frame and 0 after it.
- **FIFO overflow:** 6 back-to-back stores 0x01..0x06.
  - The first byte is popped one cycle after its push, so 0x01..0x05 are accepted and 0x06 is dropped.
  - STATUS shows full during the stores.
  - Serial output carries 0x01..0x05 only.
- **Counter:** after reset, LD CYCLE at cycle 10 → 10. SD 0xFFFFFFFFFFFFFFFE, then read 0xFFFFFFFFFFFFFFFE, 0xFFFFFFFFFFFFFFFF and 0 on successive cycles (wrap).
- **Reset mid-frame:** assert `rst` during DATA with 2 bytes queued.
  - Next cycle `uart_tx`=1 and STATUS=0.
  - RAM data written before the reset is unchanged.
  - Unmapped LD @0x2000_0000 → 0.
